sp_issue_scoreboard: RTL and testbench

//  Issue-side hazard controller for the 7-deep single-precision/multiply pipeline.

---
 rtl/sp_issue_scoreboard.sv | 81 ++++++++
 tb/tb_sp_issue_scoreboard.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sp_issue_scoreboard.sv
// Issue-side hazard scoreboard for the 7-deep SP/multiply pipeline: tracks in-flight destinations and stalls dependent issue.
// Optional feature macro: SP_FWD_EN (WB-stage forwarding shortens each hazard window by one cycle).
module sp_issue_scoreboard #(
  parameter int ADDR_W  = 7,
  parameter int FP_LAT  = 6,
  parameter int INT_LAT = 7,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_valid_i,
  input  logic              issue_int_i,
  input  logic              reg_write_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] ra_addr_i,
  input  logic [ADDR_W-1:0] rb_addr_i,
  input  logic [ADDR_W-1:0] rc_addr_i,
  input  logic [2:0]        src_use_i,
  input  logic              branch_taken_i,
  output logic              stall_o,
  output logic              issue_fire_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  stall_count_o
);

`ifdef SP_FWD_EN
  localparam int FP_LIM  = FP_LAT - 1;
  localparam int INT_LIM = INT_LAT - 1;
`else
  localparam int FP_LIM  = FP_LAT;
  localparam int INT_LIM = INT_LAT;
`endif

  logic [INT_LAT-1:0] entValid_q;
  logic [INT_LAT-1:0] entInt_q;
  logic [ADDR_W-1:0]  entAddr_q [INT_LAT];
  logic [CNT_W-1:0]   stallCount_q, stallCount_d;
  logic               hazard;
  logic               newValid;

  // Entry k belongs to the instruction issued k+1 cycles ago; it blocks readers until its class limit.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < INT_LAT; k++) begin
      if (entValid_q[k] && (entInt_q[k] ? (k < INT_LIM) : (k < FP_LIM))) begin
        if (src_use_i[2] && (entAddr_q[k] == ra_addr_i)) hazard = 1'b1;
        if (src_use_i[1] && (entAddr_q[k] == rb_addr_i)) hazard = 1'b1;
        if (src_use_i[0] && (entAddr_q[k] == rc_addr_i)) hazard = 1'b1;
      end
    end
  end

  assign stall_o      = issue_valid_i & hazard;
  assign issue_fire_o = issue_valid_i & ~hazard;
  assign busy_o       = |entValid_q;
  assign newValid     = issue_fire_o & reg_write_i & ~branch_taken_i;

  always_comb begin
    stallCount_d = stallCount_q;
    if (stall_o && !(&stallCount_q)) stallCount_d = stallCount_q + 1'b1;
  end

  // The shift never freezes: the downstream pipe advances every cycle regardless of stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entValid_q   <= '0;
      entInt_q     <= '0;
      stallCount_q <= '0;
      for (int k = 0; k < INT_LAT; k++) entAddr_q[k] <= '0;
    end else begin
      entValid_q   <= {entValid_q[INT_LAT-2:0], newValid};
      entInt_q     <= {entInt_q[INT_LAT-2:0], issue_int_i};
      entAddr_q[0] <= rt_addr_i;
      for (int k = 1; k < INT_LAT; k++) entAddr_q[k] <= entAddr_q[k-1];
      stallCount_q <= stallCount_d;
    end
  end

  assign stall_count_o = stallCount_q;

endmodule

// File: tb/tb_sp_issue_scoreboard.sv
// Self-checking bench for sp_issue_scoreboard: directed hazard scenarios plus random traffic against an age-based model.
module tb_sp_issue_scoreboard;

  localparam int FP_LAT  = 6;
  localparam int INT_LAT = 7;
`ifdef SP_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int EXP_FP_STALL  = FWD ? 5 : 6;
  localparam int EXP_INT_STALL = FWD ? 6 : 7;
  localparam int EXP_WAW_STALL = FWD ? 5 : 6;

  logic        clk = 1'b0;
  logic        rstN;
  logic        issueValid, issueInt, regWrite, branchTaken;
  logic [6:0]  rtAddr, raAddr, rbAddr, rcAddr;
  logic [2:0]  srcUse;
  logic        stall, issueFire, busy;
  logic [15:0] stallCount;

  always #5 clk = ~clk;

  sp_issue_scoreboard dut (
    .clk_i(clk), .rst_ni(rstN), .issue_valid_i(issueValid), .issue_int_i(issueInt),
    .reg_write_i(regWrite), .rt_addr_i(rtAddr), .ra_addr_i(raAddr), .rb_addr_i(rbAddr),
    .rc_addr_i(rcAddr), .src_use_i(srcUse), .branch_taken_i(branchTaken),
    .stall_o(stall), .issue_fire_o(issueFire), .busy_o(busy), .stall_count_o(stallCount)
  );

  // Model: each recorded write remembers its issue cycle; readiness is purely a function of its age.
  typedef struct {
    int         cyc;
    logic [6:0] addr;
    bit         isInt;
  } rec_t;

  rec_t        recs[$];
  int          cycle = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] modelCnt = '0;
  bit          expStall, expFire;

  function automatic int readyAge(bit isInt);
    return (isInt ? INT_LAT : FP_LAT) + (FWD ? 0 : 1);
  endfunction

  function automatic bit modelHazard(logic [6:0] a);
    foreach (recs[i]) begin
      int age = cycle - recs[i].cyc;
      if (age <= INT_LAT && age < readyAge(recs[i].isInt) && recs[i].addr == a) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive(input bit v, input bit isInt, input bit rw, input bit br,
                       input logic [6:0] rt, input logic [6:0] ra, input logic [6:0] rb,
                       input logic [6:0] rc, input logic [2:0] u);
    bit haz;
    issueValid = v; issueInt = isInt; regWrite = rw; branchTaken = br;
    rtAddr = rt; raAddr = ra; rbAddr = rb; rcAddr = rc; srcUse = u;
    haz = (u[2] && modelHazard(ra)) || (u[1] && modelHazard(rb)) || (u[0] && modelHazard(rc));
    expStall = v && haz;
    expFire  = v && !haz;
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    if (expFire && regWrite && !branchTaken)
      recs.push_back('{cyc: cycle, addr: rtAddr, isInt: issueInt});
    if (expStall && modelCnt != 16'hFFFF) modelCnt++;
    cycle++;
    while (recs.size() > 0 && (cycle - recs[0].cyc) > INT_LAT) recs.delete(0);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
      tick();
    end
  endtask

  task automatic test_reset();
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (issueFire !== 1'b0) begin errors++; $display("[TB] FAIL reset_fire got=%b exp=0", issueFire); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (stallCount !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d exp=0", stallCount); end
  endtask

  task automatic test_fp_dep();
    int stalls = 0;
    bit fired = 0;
    drive(1, 0, 1, 0, 7'd5, 7'd0, 7'd0, 7'd0, 3'b000);
    checks++; if (issueFire !== 1'b1) begin errors++; $display("[TB] FAIL fp_producer_fire got=%b exp=1", issueFire); end
    tick();
    for (int i = 0; i < 20 && !fired; i++) begin
      drive(1, 0, 1, 0, 7'd6, 7'd5, 7'd0, 7'd0, 3'b100);
      checks++; if (stall !== expStall) begin errors++; $display("[TB] FAIL fp_dep_stall cyc=%0d got=%b exp=%b", i, stall, expStall); end
      if (issueFire === 1'b1) fired = 1; else if (stall === 1'b1) stalls++;
      tick();
    end
    checks++; if (!fired) begin errors++; $display("[TB] FAIL fp_dep_fire got=0 exp=1 (timeout)"); end
    checks++; if (stalls != EXP_FP_STALL) begin errors++; $display("[TB] FAIL fp_dep_cycles got=%0d exp=%0d", stalls, EXP_FP_STALL); end
    checks++; if (stallCount !== modelCnt) begin errors++; $display("[TB] FAIL fp_dep_count got=%0d exp=%0d", stallCount, modelCnt); end
  endtask

  task automatic test_int_dep();
    int stalls = 0;
    bit fired = 0;
    drive(1, 1, 1, 0, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000);
    tick();
    for (int i = 0; i < 20 && !fired; i++) begin
      drive(1, 0, 1, 0, 7'd1, 7'd9, 7'd9, 7'd9, 3'b010);
      checks++; if (stall !== expStall) begin errors++; $display("[TB] FAIL int_dep_stall cyc=%0d got=%b exp=%b", i, stall, expStall); end
      if (issueFire === 1'b1) fired = 1; else if (stall === 1'b1) stalls++;
      tick();
    end
    checks++; if (!fired) begin errors++; $display("[TB] FAIL int_dep_fire got=0 exp=1 (timeout)"); end
    checks++; if (stalls != EXP_INT_STALL) begin errors++; $display("[TB] FAIL int_dep_cycles got=%0d exp=%0d", stalls, EXP_INT_STALL); end
  endtask

  task automatic test_branch();
    drive(1, 0, 1, 1, 7'd3, 7'd0, 7'd0, 7'd0, 3'b000);
    checks++; if (issueFire !== 1'b1) begin errors++; $display("[TB] FAIL branch_squash_fire got=%b exp=1", issueFire); end
    tick();
    drive(1, 0, 1, 0, 7'd2, 7'd3, 7'd0, 7'd0, 3'b100);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL branch_consumer_stall got=%b exp=0", stall); end
    checks++; if (issueFire !== 1'b1) begin errors++; $display("[TB] FAIL branch_consumer_fire got=%b exp=1", issueFire); end
    tick();
  endtask

  task automatic test_waw();
    int stalls = 0;
    bit fired = 0;
    drive(1, 1, 1, 0, 7'd4, 7'd0, 7'd0, 7'd0, 3'b000);
    tick();
    drive(1, 0, 1, 0, 7'd4, 7'd0, 7'd0, 7'd0, 3'b000);
    checks++; if (issueFire !== 1'b1) begin errors++; $display("[TB] FAIL waw_second_fire got=%b exp=1", issueFire); end
    tick();
    for (int i = 0; i < 20 && !fired; i++) begin
      drive(1, 0, 1, 0, 7'd8, 7'd4, 7'd0, 7'd0, 3'b100);
      checks++; if (stall !== expStall) begin errors++; $display("[TB] FAIL waw_stall cyc=%0d got=%b exp=%b", i, stall, expStall); end
      if (issueFire === 1'b1) fired = 1; else if (stall === 1'b1) stalls++;
      tick();
    end
    checks++; if (stalls != EXP_WAW_STALL || !fired) begin errors++; $display("[TB] FAIL waw_cycles got=%0d fired=%0d exp=%0d fired=1", stalls, fired, EXP_WAW_STALL); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 7'(10 + i), 7'd0, 7'd0, 7'd0, 3'b000);
      tick();
    end
    drive(1, 0, 1, 0, 7'd1, 7'd10, 7'd0, 7'd0, 3'b100);
    checks++; if (stall !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pre got stall=%b busy=%b exp 1 1", stall, busy); end
    #1 rstN = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stall got=%b exp=0", stall); end
    checks++; if (stallCount !== 16'd0) begin errors++; $display("[TB] FAIL midreset_count got=%0d exp=0", stallCount); end
    recs.delete();
    modelCnt = '0;
    issueValid = 1'b0; expStall = 0; expFire = 0;
    #1 rstN = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 4) != 0, ($urandom % 8) == 0,
            7'($urandom % 8), 7'($urandom % 8), 7'($urandom % 8), 7'($urandom % 8), 3'($urandom));
      checks++; if (stall !== expStall) begin errors++; $display("[TB] FAIL rand_stall i=%0d got=%b exp=%b", i, stall, expStall); end
      checks++; if (issueFire !== expFire) begin errors++; $display("[TB] FAIL rand_fire i=%0d got=%b exp=%b", i, issueFire, expFire); end
      checks++; if (busy !== (recs.size() != 0)) begin errors++; $display("[TB] FAIL rand_busy i=%0d got=%b exp=%b", i, busy, recs.size() != 0); end
      tick();
    end
    checks++; if (stallCount !== modelCnt) begin errors++; $display("[TB] FAIL rand_count got=%0d exp=%0d", stallCount, modelCnt); end
  endtask

  // A self-dependent mpy chain stalls on most cycles, enough to drive the counter to all-ones.
  task automatic test_saturation();
    for (int i = 0; i < 77000; i++) begin
      drive(1, 1, 1, 0, 7'd20, 7'd20, 7'd0, 7'd0, 3'b100);
      if (i == 1000) begin
        checks++; if (stallCount !== modelCnt) begin errors++; $display("[TB] FAIL sat_mid_count got=%0d exp=%0d", stallCount, modelCnt); end
      end
      tick();
    end
    checks++; if (modelCnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_model_reach got=%0d exp=65535", modelCnt); end
    checks++; if (stallCount !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_count got=%h exp=ffff", stallCount); end
  endtask

  initial begin
    rstN = 1'b0;
    issueValid = 0; issueInt = 0; regWrite = 0; branchTaken = 0;
    rtAddr = '0; raAddr = '0; rbAddr = '0; rcAddr = '0; srcUse = '0;
    expStall = 0; expFire = 0;
    #2;
    test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk) #1;
    test_fp_dep();
    idle(10);
    test_int_dep();
    idle(10);
    test_branch();
    idle(10);
    test_waw();
    idle(10);
    test_mid_reset();
    idle(2);
    test_random();
    idle(10);
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
